// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic: Gray/binary conversion
// and the flag bundle used by the read- and write-side flag generators.
package fifo_pkg;

    // Widest pointer the helpers support; callers cast to their own SIZE.
    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    typedef struct packed {
        logic empty;
        logic almost_empty;
    } rd_flags_t;

    localparam rd_flags_t RD_FLAGS_RESET = '{empty: 1'b1, almost_empty: 1'b1};

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin = gray;
        for (int i = 1; i < PTR_MAX_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock
// domain. Nothing sits between the stages so only one bit can be in flight.
import fifo_pkg::*;

module gray_sync #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] async_gray,
    output logic [SIZE-1:0] sync_gray
);

    logic [SIZE-1:0] stage1_d;
    logic [SIZE-1:0] stage1_q;
    logic [SIZE-1:0] stage2_d;
    logic [SIZE-1:0] stage2_q;

    // Straight pass-through into each stage.
    always_comb begin
        stage1_d = async_gray;
        stage2_d = stage1_q;
    end

    // Synchronizer flops; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1_q <= {SIZE{1'b0}};
            stage2_q <= {SIZE{1'b0}};
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign sync_gray = stage2_q;

endmodule

// File: rtl/empty_gen.sv
// Read-side pointer and flag generator for the dual-clock FIFO: owns the read
// pointer, synchronizes the write pointer, and registers empty/almost-empty/fill.
import fifo_pkg::*;

module empty_gen #(
    parameter int SIZE                   = 4,
    parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
    input  logic            read_clock,
    input  logic            reset,
    input  logic            valid_read,
    input  logic [SIZE-1:0] write_gray_pointer,
    output logic [SIZE-1:0] read_count,
    output logic [SIZE-1:0] read_gray,
    output logic            empty_flag,
    output logic            almost_empty_flag,
    output logic [SIZE-1:0] fill_level
);

    localparam logic [SIZE-1:0] AE_THRESH = SIZE'(ALMOST_EMPTY_THRESHOLD);
    localparam logic [SIZE-1:0] PTR_ONE   = {{(SIZE-1){1'b0}}, 1'b1};

    logic [SIZE-1:0] wsync_gray_s;
    logic [SIZE-1:0] wsync_bin_s;
    logic            read_accept_s;

    logic [SIZE-1:0] read_count_d;
    logic [SIZE-1:0] read_count_q;
    logic [SIZE-1:0] read_gray_d;
    logic [SIZE-1:0] read_gray_q;
    logic [SIZE-1:0] fill_level_d;
    logic [SIZE-1:0] fill_level_q;
    rd_flags_t       flags_d;
    rd_flags_t       flags_q;

    gray_sync #(
        .SIZE (SIZE)
    ) u_wptr_sync (
        .clk        (read_clock),
        .rst        (reset),
        .async_gray (write_gray_pointer),
        .sync_gray  (wsync_gray_s)
    );

    // Next read pointer, its Gray copy, and flags derived from the next pointer
    // so the last read raises empty on the same edge it is accepted.
    always_comb begin
        read_accept_s = valid_read & ~flags_q.empty;
        wsync_bin_s   = SIZE'(gray2bin(ptr_t'(wsync_gray_s)));

        if (read_accept_s) begin
            read_count_d = read_count_q + PTR_ONE;
        end else begin
            read_count_d = read_count_q;
        end

        read_gray_d  = SIZE'(bin2gray(ptr_t'(read_count_d)));
        fill_level_d = wsync_bin_s - read_count_d;

        flags_d.empty        = (read_gray_d == wsync_gray_s);
        flags_d.almost_empty = (fill_level_d <= AE_THRESH);
    end

    // Read-side state; every output loads its next value on each edge.
    always_ff @(posedge read_clock or posedge reset) begin
        if (reset) begin
            read_count_q <= {SIZE{1'b0}};
            read_gray_q  <= {SIZE{1'b0}};
            fill_level_q <= {SIZE{1'b0}};
            flags_q      <= RD_FLAGS_RESET;
        end else begin
            read_count_q <= read_count_d;
            read_gray_q  <= read_gray_d;
            fill_level_q <= fill_level_d;
            flags_q      <= flags_d;
        end
    end

    assign read_count        = read_count_q;
    assign read_gray         = read_gray_q;
    assign fill_level        = fill_level_q;
    assign empty_flag        = flags_q.empty;
    assign almost_empty_flag = flags_q.almost_empty;

endmodule

// File: tb/tb_empty_gen.sv
// Scoreboard bench for empty_gen: stimulus pushes expected read-side state per
// edge from an occupancy model; a monitor pops and compares after every edge.
module tb_empty_gen;

    localparam int SIZE  = 4;
    localparam int AE    = 2;
    localparam int DEPTH = 8;
    localparam int MOD   = 16;

    logic            read_clock;
    logic            reset;
    logic            valid_read;
    logic [SIZE-1:0] write_gray_pointer;
    logic [SIZE-1:0] read_count;
    logic [SIZE-1:0] read_gray;
    logic            empty_flag;
    logic            almost_empty_flag;
    logic [SIZE-1:0] fill_level;

    empty_gen #(
        .SIZE                   (SIZE),
        .ALMOST_EMPTY_THRESHOLD (AE)
    ) dut (
        .read_clock         (read_clock),
        .reset              (reset),
        .valid_read         (valid_read),
        .write_gray_pointer (write_gray_pointer),
        .read_count         (read_count),
        .read_gray          (read_gray),
        .empty_flag         (empty_flag),
        .almost_empty_flag  (almost_empty_flag),
        .fill_level         (fill_level)
    );

    initial read_clock = 1'b0;
    always #5 read_clock = ~read_clock;

    typedef struct {
        int rc;
        int rg;
        int empty;
        int ae;
        int lvl;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: reads taken so far, write pointer values as seen
    // one and two read-clock edges ago, and the last flagged emptiness.
    int m_rd;
    int m_rd_total;
    int m_seen1;
    int m_seen2;
    int m_empty;
    int wbin;

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) & (MOD - 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd       = 0;
        m_rd_total = 0;
        m_seen1    = 0;
        m_seen2    = 0;
        m_empty    = 1;
        wbin       = 0;
    endtask

    // Drive one cycle's inputs and push what the DUT must show after the edge.
    task automatic apply(input bit v, input int w);
        exp_t e;
        int   visible;
        int   rd_n;
        bit   acc;
        valid_read         = v;
        wbin               = w;
        write_gray_pointer = 4'(gray_of(w % MOD));
        acc     = v && (m_empty == 0);
        rd_n    = (m_rd + (acc ? 1 : 0)) % MOD;
        visible = m_seen2;
        m_seen2 = m_seen1;
        m_seen1 = w % MOD;
        e.rc    = rd_n;
        e.rg    = gray_of(rd_n);
        e.lvl   = (visible - rd_n + MOD) % MOD;
        e.empty = (visible == rd_n) ? 1 : 0;
        e.ae    = (e.lvl <= AE) ? 1 : 0;
        sb.push_back(e);
        m_rd    = rd_n;
        m_empty = e.empty;
        if (acc) m_rd_total++;
    endtask

    task automatic step(input bit v, input int w);
        @(negedge read_clock);
        apply(v, w);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read_count"}, int'(read_count), 0);
        check({tag, "_read_gray"}, int'(read_gray), 0);
        check({tag, "_empty"}, int'(empty_flag), 1);
        check({tag, "_almost_empty"}, int'(almost_empty_flag), 1);
        check({tag, "_fill_level"}, int'(fill_level), 0);
    endtask

    // Assert reset between edges and verify outputs clear with no clock edge.
    task automatic do_reset(input string tag);
        @(posedge read_clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        valid_read         = 1'b0;
        write_gray_pointer = 4'b0000;
        model_reset();
        @(negedge read_clock);
        reset = 1'b0;
        apply(1'b0, 0);
    endtask

    // Monitor: one expected entry per edge that the stimulus scheduled.
    initial begin
        exp_t e;
        forever begin
            @(posedge read_clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("read_count", int'(read_count), e.rc);
                check("read_gray", int'(read_gray), e.rg);
                check("empty_flag", int'(empty_flag), e.empty);
                check("almost_empty_flag", int'(almost_empty_flag), e.ae);
                check("fill_level", int'(fill_level), e.lvl);
            end
        end
    end

    initial begin
        int w;
        bit v;
        int wprob;
        valid_read         = 1'b0;
        write_gray_pointer = 4'b0000;
        reset              = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #2;
        check_reset_outputs("initial_reset");
        @(negedge read_clock);
        reset = 1'b0;
        apply(1'b0, 0);

        // Write visibility latency: pointer 0 -> 1, no reads.
        for (int i = 0; i < 4; i++) step(1'b0, 1);

        // Drain: write pointer 5, then hold valid_read high past empty.
        for (int i = 0; i < 3; i++) step(1'b0, 5);
        for (int i = 0; i < 8; i++) step(1'b1, 5);

        // Wrap-around: bring read pointer to 14, then write past the wrap.
        for (int i = 6; i <= 13; i++) step(1'b0, i);
        for (int i = 0; i < 3; i++) step(1'b0, 13);
        for (int i = 0; i < 12; i++) step(1'b1, 14);
        for (int i = 0; i < 3; i++) step(1'b0, 14);
        step(1'b0, 15);
        step(1'b0, 16);
        for (int i = 0; i < 3; i++) step(1'b0, 17);
        for (int i = 0; i < 5; i++) step(1'b1, 17);

        // Full depth from a clean pointer pair.
        do_reset("reset_before_full");
        for (int i = 0; i < 4; i++) step(1'b0, DEPTH);
        for (int i = 0; i < 3; i++) step(1'b1, DEPTH);

        // Streaming: one write and one read per cycle keeps the level steady.
        w = DEPTH;
        for (int i = 0; i < 12; i++) begin
            w++;
            step(1'b1, w);
        end

        // Randomized traffic, alternating write-heavy and read-heavy phases.
        do_reset("reset_before_random");
        for (int i = 0; i < 3000; i++) begin
            wprob = ((i / 300) % 2 == 0) ? 3 : 1;
            v     = ($urandom_range(0, 3) < 4 - wprob);
            w     = wbin;
            if (($urandom_range(0, 3) < wprob) && (w - m_rd_total < DEPTH)) w++;
            step(v, w);
        end

        // Reset asserted in the middle of a read burst.
        for (int i = 0; i < 6; i++) step(1'b0, wbin + ((wbin - m_rd_total < DEPTH) ? 1 : 0));
        for (int i = 0; i < 3; i++) step(1'b1, wbin);
        do_reset("reset_mid_burst");
        for (int i = 0; i < 4; i++) step(1'b0, 2);
        for (int i = 0; i < 4; i++) step(1'b1, 2);

        @(posedge read_clock);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
